// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-code output signal bundle
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [4:0] in_num;
    logic       intro;

    modport master (
        input  row_in,
        output col_out,
        output in_num,
        output intro
    );

    modport slave (
        output row_in,
        input  col_out,
        input  in_num,
        input  intro
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with sweep-level debounce
module keypad_scanner #(
    parameter int SCAN_DIV   = 4,
    parameter int DEBOUNCE_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = (DEBOUNCE_N < 2) ? 1 : $clog2(DEBOUNCE_N + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [4:0] CODE_NONE = 5'b11111;
    localparam logic [4:0] CODE_NOP  = 5'b10110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    logic [3:0]        sync1_q, sync2_q;
    logic [SLOT_W-1:0] slot_q;
    logic [1:0]        col_q;
    logic [1:0]        acc_hits_q;
    logic [4:0]        acc_code_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        cand_q, cand_d;
    logic [4:0]        in_num_q, in_num_d;
    logic              intro_q, intro_d;

    logic [3:0] pressed;
    logic [2:0] col_hits;
    logic [2:0] sum_hits;
    logic [1:0] sat_hits;
    logic [1:0] row_sel;
    logic [4:0] code_now;
    logic [4:0] result;
    logic       sample;
    logic       sweep_end;

    function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        case ({r, c})
            4'h0:    code = 5'd1;
            4'h1:    code = 5'd2;
            4'h2:    code = 5'd3;
            4'h3:    code = 5'b10000;
            4'h4:    code = 5'd4;
            4'h5:    code = 5'd5;
            4'h6:    code = 5'd6;
            4'h7:    code = 5'b10001;
            4'h8:    code = 5'd7;
            4'h9:    code = 5'd8;
            4'hA:    code = 5'd9;
            4'hB:    code = 5'b10010;
            4'hC:    code = 5'b10100;
            4'hD:    code = 5'd0;
            4'hE:    code = 5'b10101;
            default: code = 5'b10011;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= kp.row_in;
            sync2_q <= sync1_q;
        end
    end

    assign sample    = (slot_q == SLOT_LAST);
    assign sweep_end = sample && (col_q == 2'd3);

    // Hits are counted across the whole sweep so a chord spread over columns is rejected too.
    always_comb begin
        pressed  = ~sync2_q;
        col_hits = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
        row_sel  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pressed[i]) row_sel = 2'(i);
        end
        sum_hits = 3'(acc_hits_q) + col_hits;
        sat_hits = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
        code_now = (acc_hits_q == 2'd0) ? key_code(row_sel, col_q) : acc_code_q;
        result   = (sat_hits == 2'd1) ? code_now : CODE_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            col_q      <= 2'd0;
            acc_hits_q <= 2'd0;
            acc_code_q <= CODE_NONE;
        end else begin
            if (sample) begin
                slot_q <= '0;
                col_q  <= col_q + 2'd1;
                if (sweep_end) begin
                    acc_hits_q <= 2'd0;
                    acc_code_q <= CODE_NONE;
                end else begin
                    acc_hits_q <= sat_hits;
                    acc_code_q <= code_now;
                end
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cand_q   <= CODE_NONE;
            in_num_q <= CODE_NOP;
            intro_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            in_num_q <= in_num_d;
            intro_q  <= intro_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        in_num_d = in_num_q;
        intro_d  = 1'b0;
        if (sweep_end) begin
            case (state_q)
                S_IDLE: begin
                    if (result != CODE_NONE) begin
                        if (DEBOUNCE_N == 1) begin
                            in_num_d = result;
                            intro_d  = 1'b1;
                            cand_d   = CODE_NONE;
                            cnt_d    = '0;
                            state_d  = S_PRESSED;
                        end else begin
                            cand_d  = result;
                            cnt_d   = CNT_W'(1);
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (result == CODE_NONE) begin
                        cand_d  = CODE_NONE;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else if (result == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            in_num_d = cand_q;
                            intro_d  = 1'b1;
                            cand_d   = CODE_NONE;
                            cnt_d    = '0;
                            state_d  = S_PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cand_d = result;
                        cnt_d  = CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (result == CODE_NONE) begin
                        if (DEBOUNCE_N == 1) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = S_RELEASE;
                        end
                    end
                end
                default: begin
                    // A key seen mid-release means the previous press never really ended.
                    if (result != CODE_NONE) begin
                        cnt_d   = '0;
                        state_d = S_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign kp.col_out = ~(4'b0001 << col_q);
    assign kp.in_num  = in_num_q;
    assign kp.intro   = intro_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_mask;

    int n_pass;
    int n_total;
    int cyc_total = 0;
    int base;
    int intro_cnt = 0;
    int last_cyc  = 0;
    int c0;
    logic [4:0] last_num = 5'b0;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_total <= cyc_total + 1;

    // Physical keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.col_out[c] && key_mask[r*4+c]) rows[r] = 1'b0;
            end
        end
        kp.row_in = rows;
    end

    always @(negedge clk) begin
        if (kp.intro === 1'b1) begin
            intro_cnt <= intro_cnt + 1;
            last_num  <= kp.in_num;
            last_cyc  <= cyc_total;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_col_out", 32'(kp.col_out), 32'(4'b1110));
        chk("rst_in_num", 32'(kp.in_num), 32'(5'b10110));
        chk("rst_intro", 32'(kp.intro), 32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = cyc_total;
    endtask

    task automatic wait_rel(input int k);
        while ((cyc_total - base) < k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        key_mask = 16'h0000;
        n_pass   = 0;
        n_total  = 0;
        base     = 0;
        @(negedge clk);

        // Reset values and free-running column sequence
        do_reset();
        wait_rel(1);  chk("col_slot0", 32'(kp.col_out), 32'(4'b1110));
        wait_rel(5);  chk("col_slot1", 32'(kp.col_out), 32'(4'b1101));
        wait_rel(9);  chk("col_slot2", 32'(kp.col_out), 32'(4'b1011));
        wait_rel(13); chk("col_slot3", 32'(kp.col_out), 32'(4'b0111));
        wait_rel(17); chk("col_wrap", 32'(kp.col_out), 32'(4'b1110));
        chk("idle_no_intro", 32'(intro_cnt), 32'd0);

        // Key 6 held for 10 sweeps
        key_mask = 16'h0040;
        do_reset();
        c0 = intro_cnt;
        wait_rel(162);
        chk("hold6_count", 32'(intro_cnt - c0), 32'd1);
        chk("hold6_num", 32'(last_num), 32'(5'b00110));
        chk("hold6_cyc", 32'(last_cyc - base), 32'd48);

        // Bouncing key 5
        key_mask = 16'h0020;
        do_reset();
        c0 = intro_cnt;
        wait_rel(16); key_mask = 16'h0000;
        wait_rel(32); key_mask = 16'h0020;
        wait_rel(79);
        chk("bounce_early", 32'(intro_cnt - c0), 32'd0);
        wait_rel(160);
        chk("bounce_count", 32'(intro_cnt - c0), 32'd1);
        chk("bounce_num", 32'(last_num), 32'(5'b00101));
        chk("bounce_cyc", 32'(last_cyc - base), 32'd80);

        // Key 1 with ENTER, then ENTER alone
        key_mask = 16'h8001;
        do_reset();
        c0 = intro_cnt;
        wait_rel(80);
        chk("multi_reject", 32'(intro_cnt - c0), 32'd0);
        key_mask = 16'h8000;
        wait_rel(160);
        chk("enter_count", 32'(intro_cnt - c0), 32'd1);
        chk("enter_num", 32'(last_num), 32'(5'b10011));
        chk("enter_cyc", 32'(last_cyc - base), 32'd128);

        // Short release then re-press, full release then re-press
        key_mask = 16'h0200;
        do_reset();
        c0 = intro_cnt;
        wait_rel(64);  key_mask = 16'h0000;
        wait_rel(96);  key_mask = 16'h0002;
        wait_rel(128); key_mask = 16'h0000;
        wait_rel(170);
        chk("short_release_count", 32'(intro_cnt - c0), 32'd1);
        chk("short_release_num", 32'(kp.in_num), 32'(5'b01000));
        wait_rel(176); key_mask = 16'h0004;
        wait_rel(240);
        chk("repress_count", 32'(intro_cnt - c0), 32'd2);
        chk("repress_num", 32'(last_num), 32'(5'b00011));
        chk("repress_cyc", 32'(last_cyc - base), 32'd224);

        // Reset during the second debounce sweep of key 9
        key_mask = 16'h0400;
        do_reset();
        c0 = intro_cnt;
        wait_rel(24);
        do_reset();
        wait_rel(47);
        chk("rst_mid_early", 32'(intro_cnt - c0), 32'd0);
        wait_rel(100);
        chk("rst_mid_count", 32'(intro_cnt - c0), 32'd1);
        chk("rst_mid_num", 32'(last_num), 32'(5'b01001));
        chk("rst_mid_cyc", 32'(last_cyc - base), 32'd48);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clk cycles per column slot; legal values are 4 or more.
REQ-002 Parameter DEBOUNCE_N, default 3: consecutive identical sweeps required to accept a press or a release; legal values are 1 or more.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 row_in  input  4  keypad rows; active-low, pulled up externally.
REQ-006 col_out  output  4  keypad columns; active-low, exactly one bit low at any time.
REQ-007 in_num  output  5  key code for the stack stage; held between presses.
REQ-008 intro  output  1  key-accepted strobe, one clk wide.

Function
REQ-009 row_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-010 Column slot counter 0..SCAN_DIV-1; col_out drives column c low (c = 0..3) for its slot; rows sampled when counter = SCAN_DIV-1; column advances on the next cycle, wrapping 3 -> 0.
REQ-011 Sweep = 4 slots = 4*SCAN_DIV cycles; sweep result is evaluated at the column-3 sample.
REQ-012 Sweep result: exactly one pressed key -> its code; zero keys -> NONE; two or more keys -> NONE (ghost/multi-press rejected).
REQ-013 Key map (row,col -> code): r0: 1,2,3,PLUS=10000; r1: 4,5,6,MINUS=10001; r2: 7,8,9,BACKS=10010; r3: UP=10100, 0, DOWN=10101, ENTER=10011. Digits are encoded 0dddd.
REQ-014 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; evaluation occurs only at sweep ends.
REQ-015 IDLE: result K != NONE -> cand=K, cnt=1, DEBOUNCE; else stay.
REQ-016 DEBOUNCE: result == cand -> cnt+1; result != cand and not NONE -> cand=result, cnt=1; NONE -> IDLE.
REQ-017 When cnt reaches DEBOUNCE_N: in_num <= cand and intro = 1 for exactly the next cycle; state -> PRESSED. With DEBOUNCE_N=1, IDLE goes directly to PRESSED on the first key sweep and emits the strobe.
REQ-018 PRESSED: any non-NONE result (same or different key) is ignored; NONE -> cnt=1, RELEASE.
REQ-019 RELEASE: NONE -> cnt+1; at DEBOUNCE_N -> IDLE; any non-NONE result -> PRESSED with no strobe.
REQ-020 No auto-repeat; at most one intro per debounced press-release cycle.
REQ-021 Latency: key stable from a sweep start -> intro in the cycle after the column-3 sample of the DEBOUNCE_N-th sweep.
REQ-022 in_num changes only together with intro; intro is never asserted for NONE.
REQ-023 Scanning never stalls; col_out sequencing is independent of FSM state.

Reset
REQ-024 While rst = 1, outputs are: col_out = 4'b1110, in_num = 5'b10110 (NOP), intro = 0.
REQ-025 While rst = 1, internal state is: slot counter = 0, state = IDLE, cnt = 0, cand = NONE, synchronizer flops = 4'b1111.
REQ-026 Reset asserted mid-debounce or mid-press discards progress; no intro is emitted; scanning restarts at column 0 after release.

Verification (SCAN_DIV=4, DEBOUNCE_N=3, sweep = 16 cycles)
REQ-027 Reset: assert rst async mid-cycle -> immediately col_out=1110, in_num=10110, intro=0; after release, col_out steps 1110,1101,1011,0111 every 4 cycles.
REQ-028 Hold key r1c2 steady for 10 sweeps -> exactly one intro, in_num=00110, at the end of the 3rd sweep (+1 cycle); none afterward.
REQ-029 Bounce on key 5: present, absent, present, then stable -> single intro with in_num=00101, only after 3 consecutive sweeps of key 5.
REQ-030 Press 1 and ENTER together for 5 sweeps -> no intro; then release 1 -> intro with in_num=10011 after 3 sweeps.
REQ-031 After an accepted press, release for 2 sweeps then re-press -> no new intro; release for 3 sweeps then re-press -> new intro.
REQ-032 Assert rst during the 2nd debounce sweep of key 9, release rst, keep key held -> intro 3 full sweeps after reset release with in_num=01001; no earlier pulse.
